// File: rtl/apb_slave_node.sv
// -----------------------------------------------------------------------------
// apb_slave_node
//
// Purpose:
//   Sits downstream of the AXI-to-APB bridge. Takes its single-phase request
//   (psel+penable held until pready) and turns it into a two-phase APB3
//   SETUP/ACCESS transfer on one of NB_SLAVES peripheral ports. The target is
//   picked by an inclusive address-range decode. Completion goes back upstream
//   as a one-cycle pready with registered read data and error. Unmapped
//   addresses and slaves that never become ready are answered with pslverr.
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   start_addr_i/end_addr_i  per-slave inclusive address window, slave i at [i*AW +: AW]
//   s_p*_i / s_p*_o          upstream request and one-cycle completion
//   m_psel_o .. m_pwstrb_o   downstream APB3 request; all of these are registered
//   m_prdata_i/m_pready_i/m_pslverr_i  per-slave responses
// -----------------------------------------------------------------------------
module apb_slave_node #(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                ACLK,
    input  logic                                ARESETn,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    input  logic                                s_psel_i,
    input  logic                                s_penable_i,
    input  logic                                s_pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]           s_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]           s_pwdata_i,
    input  logic [APB_DATA_WIDTH/8-1:0]         s_pwstrb_i,
    output logic [APB_DATA_WIDTH-1:0]           s_prdata_o,
    output logic                                s_pready_o,
    output logic                                s_pslverr_o,
    output logic [NB_SLAVES-1:0]                m_psel_o,
    output logic                                m_penable_o,
    output logic                                m_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]           m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]           m_pwdata_o,
    output logic [APB_DATA_WIDTH/8-1:0]         m_pwstrb_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic [NB_SLAVES-1:0]                m_pready_i,
    input  logic [NB_SLAVES-1:0]                m_pslverr_i
);

    localparam int AW    = APB_ADDR_WIDTH;
    localparam int DW    = APB_DATA_WIDTH;
    localparam int SW    = APB_DATA_WIDTH / 8;
    localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
    // Keep the counter at least one bit wide so that TIMEOUT_CYCLES = 0 still elaborates.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NB_SLAVES-1:0] m_psel_q;
    logic                m_penable_q;
    logic                m_pwrite_q;
    logic [AW-1:0]       m_paddr_q;
    logic [DW-1:0]       m_pwdata_q;
    logic [SW-1:0]       m_pwstrb_q;
    logic [DW-1:0]       s_prdata_q;
    logic                s_pready_q;
    logic                s_pslverr_q;

    logic                hit_d;
    logic [IDX_W-1:0]    idx_d;
    logic [NB_SLAVES-1:0] sel_d;

    // Address decode. The loop runs from the top index down so that the lowest
    // hitting index is the last one written and therefore wins on overlap.
    always_comb begin
        hit_d = 1'b0;
        idx_d = '0;
        sel_d = '0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            if ((s_paddr_i >= start_addr_i[i*AW +: AW]) &&
                (s_paddr_i <= end_addr_i[i*AW +: AW])) begin
                hit_d    = 1'b1;
                idx_d    = IDX_W'(i);
                sel_d    = '0;
                sel_d[i] = 1'b1;
            end
        end
    end

    // Only the slave latched at acceptance is listened to.
    logic          sel_ready;
    logic          sel_err;
    logic [DW-1:0] sel_rdata;

    assign sel_ready = m_pready_i[idx_q];
    assign sel_err   = m_pslverr_i[idx_q];
    assign sel_rdata = m_prdata_i[idx_q*DW +: DW];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            m_pwstrb_q  <= '0;
            s_prdata_q  <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_psel_i && s_penable_i) begin
                        m_pwrite_q <= s_pwrite_i;
                        m_paddr_q  <= s_paddr_i;
                        m_pwdata_q <= s_pwdata_i;
                        m_pwstrb_q <= s_pwstrb_i;
                        idx_q      <= idx_d;
                        if (hit_d) begin
                            m_psel_q <= sel_d;
                            state_q  <= SETUP;
                        end else begin
                            // Unmapped: answer straight away without touching any slave.
                            s_pready_q  <= 1'b1;
                            s_pslverr_q <= 1'b1;
                            s_prdata_q  <= '0;
                            state_q     <= RESP;
                        end
                    end
                end
                SETUP: begin
                    m_penable_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over an expiring timeout in the same cycle.
                    if (sel_ready) begin
                        s_prdata_q  <= m_pwrite_q ? '0 : sel_rdata;
                        s_pslverr_q <= sel_err;
                        s_pready_q  <= 1'b1;
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        state_q     <= RESP;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        s_prdata_q  <= '0;
                        s_pslverr_q <= 1'b1;
                        s_pready_q  <= 1'b1;
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    s_pready_q  <= 1'b0;
                    s_pslverr_q <= 1'b0;
                    s_prdata_q  <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_psel_o    = m_psel_q;
    assign m_penable_o = m_penable_q;
    assign m_pwrite_o  = m_pwrite_q;
    assign m_paddr_o   = m_paddr_q;
    assign m_pwdata_o  = m_pwdata_q;
    assign m_pwstrb_o  = m_pwstrb_q;
    assign s_prdata_o  = s_prdata_q;
    assign s_pready_o  = s_pready_q;
    assign s_pslverr_o = s_pslverr_q;

endmodule

// File: tb/tb_apb_slave_node.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_node
//
// Purpose:
//   Directed bench for apb_slave_node. A table of transfers, each with its
//   hand-computed target, completion latency, error and read data, is applied
//   through an upstream driver and a small reactive slave model. A hand-written
//   sequence covers asynchronous reset in the middle of an ACCESS phase.
//
// Map used throughout:
//   slave0 0x0000_0000..0x0000_0FFF   slave1 0x0000_1000..0x0000_1FFF
//   slave2 0x0000_2000..0x0000_2FFF   slave3 0x0000_0100..0x8000_00FF
// -----------------------------------------------------------------------------
module tb_apb_slave_node;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [N*AW-1:0] start_addr;
    logic [N*AW-1:0] end_addr;
    logic            s_psel, s_penable, s_pwrite;
    logic [AW-1:0]   s_paddr;
    logic [DW-1:0]   s_pwdata;
    logic [DW/8-1:0] s_pwstrb;
    logic [DW-1:0]   s_prdata_o;
    logic            s_pready_o, s_pslverr_o;
    logic [N-1:0]    m_psel_o;
    logic            m_penable_o, m_pwrite_o;
    logic [AW-1:0]   m_paddr_o;
    logic [DW-1:0]   m_pwdata_o;
    logic [DW/8-1:0] m_pwstrb_o;
    logic [N*DW-1:0] m_prdata;
    logic [N-1:0]    m_pready, m_pslverr;

    apb_slave_node #(
        .NB_SLAVES     (N),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .start_addr_i(start_addr),
        .end_addr_i  (end_addr),
        .s_psel_i    (s_psel),
        .s_penable_i (s_penable),
        .s_pwrite_i  (s_pwrite),
        .s_paddr_i   (s_paddr),
        .s_pwdata_i  (s_pwdata),
        .s_pwstrb_i  (s_pwstrb),
        .s_prdata_o  (s_prdata_o),
        .s_pready_o  (s_pready_o),
        .s_pslverr_o (s_pslverr_o),
        .m_psel_o    (m_psel_o),
        .m_penable_o (m_penable_o),
        .m_pwrite_o  (m_pwrite_o),
        .m_paddr_o   (m_paddr_o),
        .m_pwdata_o  (m_pwdata_o),
        .m_pwstrb_o  (m_pwstrb_o),
        .m_prdata_i  (m_prdata),
        .m_pready_i  (m_pready),
        .m_pslverr_i (m_pslverr)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wait_n;     // ACCESS cycles with pready low before the slave answers
        logic [31:0] srdata;     // data the selected slave drives
        logic        serr;       // pslverr the selected slave drives
        logic [3:0]  exp_sel;
        int          exp_lat;    // cycles from acceptance to the s_pready_o pulse
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NEVER = 255;
    localparam int NV    = 10;
    vec_t vecs [NV];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Selected slave answers after wait_n ACCESS cycles; every other slave drives
    // ready, error and all-ones data, none of which may leak through.
    task automatic drive_slaves(input vec_t v, input int acc);
        for (int i = 0; i < N; i++) begin
            if (v.exp_sel[i]) begin
                m_pready[i]            = m_penable_o && (acc >= v.wait_n);
                m_pslverr[i]           = v.serr;
                m_prdata[i*DW +: DW]   = v.srdata;
            end else begin
                m_pready[i]            = 1'b1;
                m_pslverr[i]           = 1'b1;
                m_prdata[i*DW +: DW]   = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int acc;
        int lat;
        acc = 0;
        lat = -1;
        s_psel    = 1'b1;
        s_penable = 1'b1;
        s_pwrite  = v.wr;
        s_paddr   = v.addr;
        s_pwdata  = v.wdata;
        s_pwstrb  = v.strb;
        drive_slaves(v, 0);
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            tick();
            if (k == 1)
                check($sformatf("v%0d setup {penable,psel}", n),
                      {27'd0, m_penable_o, m_psel_o}, {27'd0, 1'b0, v.exp_sel});
            if (k == 2 && v.exp_sel != 4'd0) begin
                check($sformatf("v%0d access {penable,psel}", n),
                      {27'd0, m_penable_o, m_psel_o}, {27'd0, 1'b1, v.exp_sel});
                check($sformatf("v%0d m_paddr", n), m_paddr_o, v.addr);
                check($sformatf("v%0d m_pwdata", n), m_pwdata_o, v.wdata);
                check($sformatf("v%0d {m_pwrite,m_pwstrb}", n),
                      {27'd0, m_pwrite_o, m_pwstrb_o}, {27'd0, v.wr, v.strb});
            end
            if (s_pready_o) begin
                lat = k;
                check($sformatf("v%0d s_pslverr", n), {31'd0, s_pslverr_o}, {31'd0, v.exp_err});
                check($sformatf("v%0d s_prdata", n), s_prdata_o, v.exp_rdata);
                check($sformatf("v%0d psel low in RESP", n), {28'd0, m_psel_o}, 32'd0);
            end else begin
                drive_slaves(v, acc);
                if (m_penable_o) acc++;
            end
        end
        s_psel    = 1'b0;
        s_penable = 1'b0;
        check($sformatf("v%0d latency", n), 32'(lat), 32'(v.exp_lat));
        tick();
        check($sformatf("v%0d after pulse {pready,err,penable,psel}", n),
              {25'd0, s_pready_o, s_pslverr_o, m_penable_o, m_psel_o}, 32'd0);
        check($sformatf("v%0d s_prdata outside RESP", n), s_prdata_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t rv;

        start_addr = {32'h0000_0100, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
        end_addr   = {32'h8000_00FF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF};
        s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0;
        s_paddr = '0; s_pwdata = '0; s_pwstrb = '0;
        m_prdata = '0; m_pready = '0; m_pslverr = '0;

        //          wr    addr          wdata         strb  wait   srdata        serr  sel      lat err  exp_rdata
        vecs[0] = '{1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 0,     32'h1111_1111, 1'b0, 4'b0010, 3,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_2010, 32'h0,         4'h0, 5,     32'h1234_5678, 1'b0, 4'b0100, 8,  1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'hF000_0000, 32'h0,         4'h0, 0,     32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, NEVER, 32'h7777_7777, 1'b0, 4'b0001, 10, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 0,     32'h1212_1212, 1'b1, 4'b0001, 3,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_1FFF, 32'h0,         4'h0, 0,     32'hCAFE_F00D, 1'b0, 4'b0010, 3,  1'b0, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h8000_00FF, 32'h0,         4'h0, 1,     32'h0BAD_F00D, 1'b1, 4'b1000, 4,  1'b1, 32'h0BAD_F00D};
        vecs[7] = '{1'b0, 32'h8000_0100, 32'h0,         4'h0, 0,     32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_2000, 32'h0,         4'h0, 7,     32'h55AA_33CC, 1'b0, 4'b0100, 10, 1'b0, 32'h55AA_33CC};
        vecs[9] = '{1'b1, 32'h0000_0FFF, 32'h0F0F_0F0F, 4'h8, 0,     32'h9999_9999, 1'b0, 4'b0001, 3,  1'b0, 32'h0};

        // Reset state, with a request already present upstream.
        s_psel = 1'b1; s_penable = 1'b1; s_paddr = 32'h0000_1004; s_pwdata = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("reset {pready,err,penable,psel}",
              {25'd0, s_pready_o, s_pslverr_o, m_penable_o, m_psel_o}, 32'd0);
        check("reset s_prdata", s_prdata_o, 32'd0);
        check("reset m_paddr", m_paddr_o, 32'd0);
        check("reset m_pwdata", m_pwdata_o, 32'd0);
        check("reset {m_pwrite,m_pwstrb}", {27'd0, m_pwrite_o, m_pwstrb_o}, 32'd0);
        s_psel = 1'b0; s_penable = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset asserted in the middle of an ACCESS phase on slave2.
        rv = '{1'b0, 32'h0000_2010, 32'h0, 4'h0, NEVER, 32'h4444_4444, 1'b0, 4'b0100, 0, 1'b0, 32'h0};
        s_psel = 1'b1; s_penable = 1'b1; s_pwrite = 1'b0; s_paddr = rv.addr;
        drive_slaves(rv, 0);
        tick();
        drive_slaves(rv, 0);
        tick();
        check("rst-mid access {penable,psel}", {27'd0, m_penable_o, m_psel_o}, {27'd0, 1'b1, 4'b0100});
        #2;
        ARESETn = 1'b0;
        #1;
        check("rst-mid async {penable,psel}", {27'd0, m_penable_o, m_psel_o}, 32'd0);
        check("rst-mid async s_pready", {31'd0, s_pready_o}, 32'd0);
        s_psel = 1'b0; s_penable = 1'b0;
        repeat (2) tick();
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        run_vec(vecs[0], 100);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
